// File: rtl/audio_pkg.sv
// Shared widths, volume encoding, FSM states and the accumulator clamp for the audio mixer.
// No latency or backpressure of its own; the contents are used only by the mixer modules.
package audio_pkg;

    localparam int SAMPLE_W = 8;
    localparam int OUT_W    = 16;
    localparam int ACC_W    = 18;

    localparam logic [1:0] VOL_OFF = 2'd0;
    localparam logic [1:0] VOL_SH5 = 2'd1;
    localparam logic [1:0] VOL_SH6 = 2'd2;
    localparam logic [1:0] VOL_SH7 = 2'd3;

    localparam logic signed [ACC_W-1:0] ACC_MAX = 18'sd32767;
    localparam logic signed [ACC_W-1:0] ACC_MIN = -18'sd32768;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_SAT,
        ST_FILT
    } mix_state_t;

    function automatic logic signed [OUT_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
        if (acc > ACC_MAX) begin
            return 16'sh7fff;
        end else if (acc < ACC_MIN) begin
            return 16'sh8000;
        end else begin
            return acc[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/one_pole_lpf.sv
// One-pole low-pass y += (x - y) >>> FILT_SHIFT, or a plain register when FILT_SHIFT = 0.
// Latency: y updates on the clock edge where en is high. Backpressure: none, en is a strobe.
module one_pole_lpf #(
    parameter int FILT_SHIFT = 2,
    parameter int WIDTH      = 16
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);

    logic signed [WIDTH-1:0] y_next;

    generate
        if (FILT_SHIFT == 0) begin : g_bypass
            always_comb begin
                y_next = x;
            end
        end else begin : g_filt
            logic signed [WIDTH:0] x_ext;
            logic signed [WIDTH:0] y_ext;
            logic signed [WIDTH:0] diff;
            logic signed [WIDTH:0] y_sum;

            // The new value lies between the old y and x, so it never leaves WIDTH bits.
            always_comb begin
                x_ext = {x[WIDTH-1], x};
                y_ext = {y[WIDTH-1], y};
                diff  = x_ext - y_ext;
                y_sum = y_ext + (diff >>> FILT_SHIFT);
                y_next = WIDTH'(y_sum);
            end
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            y <= '0;
        end else if (en) begin
            y <= y_next;
        end
    end

endmodule

// File: rtl/audio_mix_stage.sv
// Time-multiplexed mixer: snapshots channels, sums volume/pan-scaled terms with clamping, filters.
// Latency: CHANNELS+2 clocks from ce_sample; strobes arriving while busy are dropped (overrun pulse).
module audio_mix_stage
    import audio_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int FILT_SHIFT = 2
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic                           ce_sample,
    input  logic [CHANNELS*SAMPLE_W-1:0]   ch_sample,
    input  logic [CHANNELS*2-1:0]          ch_vol,
    input  logic [CHANNELS*2-1:0]          ch_pan,
    input  logic                           mute,
    output logic [OUT_W-1:0]               audio_l,
    output logic [OUT_W-1:0]               audio_r,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

    mix_state_t                         state;
    logic [CHANNELS*SAMPLE_W-1:0]       snap_sample;
    logic [CHANNELS*2-1:0]              snap_vol;
    logic [CHANNELS*2-1:0]              snap_pan;
    logic [IDX_W-1:0]                   idx;
    logic signed [ACC_W-1:0]            acc_l;
    logic signed [ACC_W-1:0]            acc_r;
    logic signed [OUT_W-1:0]            sat_l;
    logic signed [OUT_W-1:0]            sat_r;

    logic signed [SAMPLE_W:0]           s;
    logic signed [ACC_W-1:0]            s_ext;
    logic signed [ACC_W-1:0]            term;
    logic                               lpf_en;
    logic signed [OUT_W-1:0]            lpf_x_l;
    logic signed [OUT_W-1:0]            lpf_x_r;
    logic signed [OUT_W-1:0]            lpf_y_l;
    logic signed [OUT_W-1:0]            lpf_y_r;

    // The snapshot shifts down one channel per ACC cycle, so the current channel is always lane 0.
    always_comb begin
        s     = $signed({1'b0, snap_sample[SAMPLE_W-1:0]}) - 9'sd128;
        s_ext = s;
        case (snap_vol[1:0])
            VOL_SH5: term = s_ext <<< 5;
            VOL_SH6: term = s_ext <<< 6;
            VOL_SH7: term = s_ext <<< 7;
            default: term = '0;
        endcase
    end

    always_comb begin
        lpf_en  = (state == ST_FILT);
        lpf_x_l = mute ? '0 : sat_l;
        lpf_x_r = mute ? '0 : sat_r;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            snap_sample <= '0;
            snap_vol    <= '0;
            snap_pan    <= '0;
            idx         <= '0;
            acc_l       <= '0;
            acc_r       <= '0;
            sat_l       <= '0;
            sat_r       <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= ce_sample && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (ce_sample) begin
                        snap_sample <= ch_sample;
                        snap_vol    <= ch_vol;
                        snap_pan    <= ch_pan;
                        acc_l       <= '0;
                        acc_r       <= '0;
                        idx         <= '0;
                        busy        <= 1'b1;
                        state       <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (snap_pan[0]) acc_l <= acc_l + term;
                    if (snap_pan[1]) acc_r <= acc_r + term;
                    snap_sample <= snap_sample >> SAMPLE_W;
                    snap_vol    <= snap_vol >> 2;
                    snap_pan    <= snap_pan >> 2;
                    if (idx == IDX_LAST) begin
                        state <= ST_SAT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_SAT: begin
                    sat_l <= sat16(acc_l);
                    sat_r <= sat16(acc_r);
                    state <= ST_FILT;
                end
                ST_FILT: begin
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    one_pole_lpf #(.FILT_SHIFT(FILT_SHIFT), .WIDTH(OUT_W)) u_lpf_l (
        .clk_sys (clk_sys),
        .reset   (reset),
        .en      (lpf_en),
        .x       (lpf_x_l),
        .y       (lpf_y_l)
    );

    one_pole_lpf #(.FILT_SHIFT(FILT_SHIFT), .WIDTH(OUT_W)) u_lpf_r (
        .clk_sys (clk_sys),
        .reset   (reset),
        .en      (lpf_en),
        .x       (lpf_x_r),
        .y       (lpf_y_r)
    );

    assign audio_l = lpf_y_l;
    assign audio_r = lpf_y_r;

endmodule

// File: tb/tb_audio_mix_stage.sv
// Drives an unfiltered and a filtered mixer with the same stimulus and compares each against
// a plain-arithmetic model of the mix, clamp and one-pole filter.
module tb_audio_mix_stage;

    localparam int CH  = 4;
    localparam int SH  = 2;
    localparam int LAT = CH + 2;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ce_sample;
    logic [CH*8-1:0] ch_sample;
    logic [CH*2-1:0] ch_vol;
    logic [CH*2-1:0] ch_pan;
    logic          mute;

    logic [15:0]   a_l, a_r, b_l, b_r;
    logic          a_vld, a_busy, a_ovr, b_vld, b_busy, b_ovr;

    int checks = 0;
    int errors = 0;
    int ovr_a  = 0;
    int samp[CH];
    int vol[CH];
    int pan[CH];
    int yl_m = 0;
    int yr_m = 0;

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (a_ovr === 1'b1) ovr_a++;
    end

    audio_mix_stage #(.CHANNELS(CH), .FILT_SHIFT(0)) dut_a (
        .clk_sys(clk_sys), .reset(reset), .ce_sample(ce_sample), .ch_sample(ch_sample),
        .ch_vol(ch_vol), .ch_pan(ch_pan), .mute(mute), .audio_l(a_l), .audio_r(a_r),
        .out_valid(a_vld), .busy(a_busy), .overrun(a_ovr)
    );

    audio_mix_stage #(.CHANNELS(CH), .FILT_SHIFT(SH)) dut_b (
        .clk_sys(clk_sys), .reset(reset), .ce_sample(ce_sample), .ch_sample(ch_sample),
        .ch_vol(ch_vol), .ch_pan(ch_pan), .mute(mute), .audio_l(b_l), .audio_r(b_r),
        .out_valid(b_vld), .busy(b_busy), .overrun(b_ovr)
    );

    function automatic int mix_side(input int side);
        int sum = 0;
        for (int c = 0; c < CH; c++) begin
            if (((pan[c] >> side) & 1) == 1 && vol[c] != 0)
                sum += (samp[c] - 128) * (1 << (vol[c] + 4));
        end
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return sum;
    endfunction

    function automatic int lpf_step(input int y, input int x);
        int d = x - y;
        int q;
        if (d >= 0) q = d / (1 << SH);
        else        q = -((-d + (1 << SH) - 1) / (1 << SH));
        return y + q;
    endfunction

    task automatic apply_inputs();
        for (int c = 0; c < CH; c++) begin
            ch_sample[c*8 +: 8] = 8'(samp[c]);
            ch_vol[c*2 +: 2]    = 2'(vol[c]);
            ch_pan[c*2 +: 2]    = 2'(pan[c]);
        end
    endtask

    task automatic set_all(input int s, input int v, input int p);
        for (int c = 0; c < CH; c++) begin
            samp[c] = s; vol[c] = v; pan[c] = p;
        end
        apply_inputs();
    endtask

    // Expected unfiltered (mute applied) and filtered outputs; advances the filter model.
    task automatic compute_expected(output int xl, output int xr, output int fl, output int fr);
        xl = mute ? 0 : mix_side(0);
        xr = mute ? 0 : mix_side(1);
        yl_m = lpf_step(yl_m, xl);
        yr_m = lpf_step(yr_m, xr);
        fl = yl_m;
        fr = yr_m;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce_sample = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
        yl_m = 0;
        yr_m = 0;
    endtask

    // Pulses ce_sample, scrambles inputs after the snapshot edge, waits for out_valid.
    task automatic run_strobe(output int lat, output logic busy0);
        ce_sample = 1'b1;
        @(posedge clk_sys);
        #1 ce_sample = 1'b0;
        busy0 = a_busy;
        ch_sample = $urandom;
        ch_vol    = 8'($urandom);
        ch_pan    = 8'($urandom);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk_sys);
            #1;
            if (a_vld === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        mute = 1'b0;
        set_all(128, 0, 0);
        do_reset();
        checks++;
        if (a_l !== 16'd0 || a_r !== 16'd0 || b_l !== 16'd0 || b_r !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%0d/%0d b=%0d/%0d required 0", a_l, a_r, b_l, b_r);
        end
        checks++;
        if ({a_vld, a_busy, a_ovr, b_vld, b_busy, b_ovr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {a_vld, a_busy, a_ovr, b_vld, b_busy, b_ovr});
        end
    endtask

    task automatic test_silence();
        int xl, xr, fl, fr, lat;
        logic busy0;
        set_all(128, 3, 3);
        compute_expected(xl, xr, fl, fr);
        run_strobe(lat, busy0);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL silence_latency: got %0d required %0d", lat, LAT);
        end
        checks++;
        if (busy0 !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL silence_busy: got rise=%b after=%b required 1/0", busy0, a_busy);
        end
        checks++;
        if (a_l !== 16'(xl) || a_r !== 16'(xr) || b_vld !== 1'b1) begin
            errors++;
            $display("FAIL silence_value: got %0d/%0d bvld=%b required 0/0 bvld=1",
                     $signed(a_l), $signed(a_r), b_vld);
        end
    endtask

    task automatic test_single();
        int xl, xr, fl, fr, lat;
        logic busy0;
        set_all(128, 0, 0);
        samp[0] = 255; vol[0] = 3; pan[0] = 1;
        apply_inputs();
        compute_expected(xl, xr, fl, fr);
        run_strobe(lat, busy0);
        checks++;
        if (a_l !== 16'd16256 || a_r !== 16'd0 || xl != 16256) begin
            errors++;
            $display("FAIL single_left: got %0d/%0d model %0d required 16256/0",
                     $signed(a_l), $signed(a_r), xl);
        end
        checks++;
        if (b_l !== 16'(fl) || b_r !== 16'(fr)) begin
            errors++;
            $display("FAIL single_filt: got %0d/%0d required %0d/%0d", $signed(b_l), $signed(b_r), fl, fr);
        end
        @(posedge clk_sys);
        #1;
        checks++;
        if (a_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_vld_pulse: got %b required 0", a_vld);
        end
    endtask

    task automatic test_saturate();
        int xl, xr, fl, fr, lat;
        logic busy0;
        set_all(255, 3, 3);
        compute_expected(xl, xr, fl, fr);
        run_strobe(lat, busy0);
        checks++;
        if (a_l !== 16'h7fff || a_r !== 16'h7fff) begin
            errors++;
            $display("FAIL sat_pos: got %0d/%0d required 32767/32767", $signed(a_l), $signed(a_r));
        end
        set_all(0, 3, 3);
        compute_expected(xl, xr, fl, fr);
        run_strobe(lat, busy0);
        checks++;
        if (a_l !== 16'h8000 || a_r !== 16'h8000) begin
            errors++;
            $display("FAIL sat_neg: got %0d/%0d required -32768/-32768", $signed(a_l), $signed(a_r));
        end
        checks++;
        if (b_l !== 16'(fl) || b_r !== 16'(fr)) begin
            errors++;
            $display("FAIL sat_filt: got %0d/%0d required %0d/%0d", $signed(b_l), $signed(b_r), fl, fr);
        end
    endtask

    task automatic test_filter();
        int xl, xr, fl, fr, lat, prev;
        logic busy0;
        do_reset();
        mute = 1'b0;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            set_all(128, 0, 0);
            samp[0] = 255; vol[0] = 3; pan[0] = 1;
            apply_inputs();
            compute_expected(xl, xr, fl, fr);
            run_strobe(lat, busy0);
            checks++;
            if (b_l !== 16'(fl) || b_r !== 16'd0) begin
                errors++;
                $display("FAIL filt_step%0d: got %0d/%0d required %0d/0", i, $signed(b_l), $signed(b_r), fl);
            end
            if (i < 2) begin
                checks++;
                if (b_l !== ((i == 0) ? 16'd4064 : 16'd7112)) begin
                    errors++;
                    $display("FAIL filt_known%0d: got %0d required %0d", i, $signed(b_l),
                             (i == 0) ? 4064 : 7112);
                end
            end
            checks++;
            if (!($signed(b_l) > prev)) begin
                errors++;
                $display("FAIL filt_rise%0d: got %0d required above %0d", i, $signed(b_l), prev);
            end
            prev = $signed(b_l);
        end
        mute = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compute_expected(xl, xr, fl, fr);
            run_strobe(lat, busy0);
            checks++;
            if (b_l !== 16'(fl) || !($signed(b_l) < prev) || $signed(b_l) < 0 || a_l !== 16'd0) begin
                errors++;
                $display("FAIL mute_decay%0d: got %0d (a=%0d) required %0d below %0d, a=0",
                         i, $signed(b_l), $signed(a_l), fl, prev);
            end
            prev = $signed(b_l);
        end
        mute = 1'b0;
    endtask

    task automatic test_overrun();
        int xl, xr, fl, fr, vld_cnt, ovr0;
        logic [15:0] got_l, got_r;
        for (int c = 0; c < CH; c++) begin
            samp[c] = 40 + 50 * c; vol[c] = c % 4; pan[c] = 3 - (c % 3);
        end
        apply_inputs();
        compute_expected(xl, xr, fl, fr);
        ovr0 = ovr_a;
        ce_sample = 1'b1;
        @(posedge clk_sys);
        #1 ce_sample = 1'b0;
        set_all(255, 3, 3);
        @(posedge clk_sys);
        #1 ce_sample = 1'b1;
        @(posedge clk_sys);
        #1 ce_sample = 1'b0;
        checks++;
        if (a_ovr !== 1'b1 || b_ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got %b/%b required 1/1", a_ovr, b_ovr);
        end
        vld_cnt = 0;
        got_l = 'x;
        got_r = 'x;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk_sys);
            #1;
            if (a_vld === 1'b1) begin
                vld_cnt++;
                got_l = a_l;
                got_r = a_r;
            end
        end
        checks++;
        if (ovr_a - ovr0 != 1) begin
            errors++;
            $display("FAIL overrun_count: got %0d required 1", ovr_a - ovr0);
        end
        checks++;
        if (vld_cnt != 1 || got_l !== 16'(xl) || got_r !== 16'(xr)) begin
            errors++;
            $display("FAIL overrun_result: got %0d pulses %0d/%0d required 1 pulse %0d/%0d",
                     vld_cnt, $signed(got_l), $signed(got_r), xl, xr);
        end
        checks++;
        if (b_l !== 16'(fl) || b_r !== 16'(fr)) begin
            errors++;
            $display("FAIL overrun_filt: got %0d/%0d required %0d/%0d", $signed(b_l), $signed(b_r), fl, fr);
        end
    endtask

    task automatic test_reset_mid();
        int xl, xr, fl, fr, lat;
        logic busy0;
        set_all(200, 2, 3);
        compute_expected(xl, xr, fl, fr);
        run_strobe(lat, busy0);
        ce_sample = 1'b1;
        @(posedge clk_sys);
        #1 ce_sample = 1'b0;
        @(posedge clk_sys);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (a_l !== 16'd0 || b_l !== 16'd0 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got a=%0d b=%0d busy=%b/%b required 0 0 0/0",
                     $signed(a_l), $signed(b_l), a_busy, b_busy);
        end
        @(posedge clk_sys);
        #1 reset = 1'b0;
        yl_m = 0;
        yr_m = 0;
        set_all(10, 1, 2);
        compute_expected(xl, xr, fl, fr);
        run_strobe(lat, busy0);
        checks++;
        if (lat !== LAT || a_l !== 16'(xl) || a_r !== 16'(xr) || b_r !== 16'(fr)) begin
            errors++;
            $display("FAIL reset_recover: got lat=%0d %0d/%0d b_r=%0d required %0d %0d/%0d %0d",
                     lat, $signed(a_l), $signed(a_r), $signed(b_r), LAT, xl, xr, fr);
        end
    endtask

    task automatic test_random();
        int xl, xr, fl, fr, lat;
        logic busy0;
        for (int i = 0; i < 24; i++) begin
            for (int c = 0; c < CH; c++) begin
                samp[c] = $urandom_range(0, 255);
                vol[c]  = $urandom_range(0, 3);
                pan[c]  = $urandom_range(0, 3);
            end
            mute = ($urandom_range(0, 4) == 0);
            apply_inputs();
            compute_expected(xl, xr, fl, fr);
            run_strobe(lat, busy0);
            checks++;
            if (lat !== LAT || a_l !== 16'(xl) || a_r !== 16'(xr) ||
                b_l !== 16'(fl) || b_r !== 16'(fr)) begin
                errors++;
                $display("FAIL random%0d: got lat=%0d a=%0d/%0d b=%0d/%0d required %0d a=%0d/%0d b=%0d/%0d",
                         i, lat, $signed(a_l), $signed(a_r), $signed(b_l), $signed(b_r),
                         LAT, xl, xr, fl, fr);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk_sys);
                #1;
            end
        end
        mute = 1'b0;
    endtask

    task automatic test_back_to_back();
        int xl, xr, fl, fr, lat, ovr0, good;
        logic busy0;
        ovr0 = ovr_a;
        good = 0;
        for (int i = 0; i < 6; i++) begin
            set_all(128 + 20 * i, 3, 1 + (i % 3));
            compute_expected(xl, xr, fl, fr);
            run_strobe(lat, busy0);
            if (lat == LAT && a_l === 16'(xl) && a_r === 16'(xr) && b_l === 16'(fl)) good++;
        end
        checks++;
        if (good != 6 || ovr_a != ovr0) begin
            errors++;
            $display("FAIL back_to_back: got %0d good, %0d overruns required 6 good, 0 overruns",
                     good, ovr_a - ovr0);
        end
    endtask

    initial begin
        test_reset();
        test_silence();
        test_single();
        test_saturate();
        test_filter();
        test_overrun();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
